sha1_iter: RTL and testbench
============================

SHA1_ITER -- requirements
Module: sha1_iter

Interface
REQ-001 SHALL have parameter UNROLL, default 1, meaning SHA-1 rounds computed per clock; legal values 1,2,4,5,8,10,16,20; any other value SHALL fail elaboration.
REQ-002 SHALL have parameter CHAIN_EN, default 1, meaning 1 = multi-block chaining supported, 0 = every block starts from the standard IV.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port din  input  512  one message block; din[511:480] = W0 through din[31:0] = W15, each word big-endian.
REQ-006 SHALL have port din_first  input  1  sampled with din; 1 = first block of a message.
REQ-007 SHALL have port din_vld  input  1  block offer.
REQ-008 SHALL have port din_rdy  output  1  engine can accept a block.
REQ-009 SHALL have port dout  output  160  digest; dout[159:128] = H0 through dout[31:0] = H4.
REQ-010 SHALL have port dout_vld  output  1  dout holds a valid digest.
REQ-011 SHALL have port dout_rdy  input  1  consumer accepts dout.
REQ-012 SHALL have port busy  output  1  high in RUN or DONE state.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-014 din_rdy SHALL equal 1 exactly in IDLE; a block is accepted on an edge where din_vld && din_rdy.
REQ-015 On accept: SHALL load a..e from the chaining register H, or from IV 67452301 EFCDAB89 98BADCFE 10325476 C3D2E1F0 when din_first = 1 or CHAIN_EN = 0; SHALL load the 16-word schedule window from din; SHALL clear round counter; state -> RUN.
REQ-016 In RUN, each cycle SHALL perform rounds t..t+UNROLL-1 combinationally chained: f/K per FIPS 180-4 (t 0-19 Ch/5A827999, 20-39 Parity/6ED9EBA1, 40-59 Maj/8F1BBCDC, 60-79 Parity/CA62C1D6); all additions modulo 2^32.
REQ-017 Schedule SHALL be a 16-word sliding window: Wt = ROTL1(Wt-3 ^ Wt-8 ^ Wt-14 ^ Wt-16) for t >= 16, advancing UNROLL words per cycle; no 80-word storage.
REQ-018 Round counter SHALL count 0..80-UNROLL in steps of UNROLL; no wrap beyond 79.
REQ-019 On the RUN edge completing round 79: SHALL register dout = {H0+a, H1+b, H2+c, H3+d, H4+e} using the block's starting values, SHALL write the same value into H, SHALL set dout_vld = 1, state -> DONE.
REQ-020 Latency: dout_vld SHALL rise exactly 80/UNROLL clock edges after the accept edge (80 for UNROLL=1, 4 for UNROLL=20).
REQ-021 In DONE, dout and dout_vld SHALL hold stable until an edge with dout_rdy = 1; on that edge dout_vld -> 0, state -> IDLE; din_rdy rises the following cycle.
REQ-022 dout_rdy asserted while dout_vld = 0 SHALL have no effect; din_vld while din_rdy = 0 SHALL be ignored (no queuing).
REQ-023 Block throughput SHALL be one block per 80/UNROLL + 2 cycles when dout_rdy is held high.
REQ-024 dout SHALL retain the last digest after dout_vld falls until overwritten by the next completion.

Reset
REQ-025 While rstn = 0, asynchronously: state = IDLE, din_rdy = 1, busy = 0, dout_vld = 0, dout = 0, H = IV, counter = 0.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abort the block with no digest emitted; first accept after release SHALL behave as a fresh message regardless of din_first.

Verification
REQ-027 "abc" block (W0 = 61626380, W1..W14 = 0, W15 = 00000018), din_first = 1 -> dout = a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d after 80/UNROLL edges.
REQ-028 Empty-message block (W0 = 80000000, rest 0), din_first = 1 -> dout = da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709.
REQ-029 Two padded blocks of "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", first with din_first = 1, second with 0 -> final dout = 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1; with CHAIN_EN = 0 the second digest SHALL differ.
REQ-030 dout_rdy held low 20 cycles after completion -> dout_vld and dout stable, din_rdy = 0, din_vld pulses ignored; dout_rdy high -> IDLE next edge.
REQ-031 rstn pulsed low at round 40 of a block -> outputs at reset values immediately; subsequent "abc" block with din_first = 0 -> still a9993e36...9cd0d89d.
REQ-032 Run REQ-027..REQ-031 for UNROLL = 1, 5, 20 and check latency per REQ-020 and throughput per REQ-023.

Source files
------------

// File: rtl/sha1_iter.sv
// Iterative SHA-1 compression engine: UNROLL rounds per clock over a 16-word sliding
// schedule window, with optional multi-block chaining through the H register.
module sha1_iter #(
   parameter int UNROLL   = 1,
   parameter bit CHAIN_EN = 1'b1
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [511:0] din,
   input  logic         din_first,
   input  logic         din_vld,
   output logic         din_rdy,
   output logic [159:0] dout,
   output logic         dout_vld,
   input  logic         dout_rdy,
   output logic         busy
);

   localparam logic [159:0] IV   = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
   localparam logic [6:0]   LAST = 7'(80 - UNROLL);
   localparam logic [6:0]   STEP = 7'(UNROLL);

   generate
      if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 5 &&
          UNROLL != 8 && UNROLL != 10 && UNROLL != 16 && UNROLL != 20) begin : g_bad_unroll
         $error("sha1_iter: UNROLL must divide 80 and be one of 1,2,4,5,8,10,16,20");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_nxt;
   logic [6:0]    cnt;
   logic [159:0]  h_q;
   logic [159:0]  start_q;
   logic [159:0]  v_q;
   logic [31:0]   win_q [16];
   logic [159:0]  vn;
   logic [31:0]   wn [16];
   logic [31:0]   nw;
   logic [159:0]  digest;
   logic          accept;
   logic          last_edge;
   logic [159:0]  init_val;

   function automatic logic [159:0] sha1_round(input logic [159:0] s, input logic [31:0] w,
                                               input logic [6:0] t);
      logic [31:0] a, b, c, d, e, f, k, tmp;
      {a, b, c, d, e} = s;
      if (t < 7'd20) begin
         f = (b & c) | (~b & d);
         k = 32'h5A827999;
      end else if (t < 7'd40) begin
         f = b ^ c ^ d;
         k = 32'h6ED9EBA1;
      end else if (t < 7'd60) begin
         f = (b & c) | (b & d) | (c & d);
         k = 32'h8F1BBCDC;
      end else begin
         f = b ^ c ^ d;
         k = 32'hCA62C1D6;
      end
      tmp = {a[26:0], a[31:27]} + f + e + k + w;
      return {tmp, a, {b[1:0], b[31:2]}, c, d};
   endfunction

   assign din_rdy   = (state == IDLE);
   assign busy      = (state != IDLE);
   assign dout_vld  = (state == DONE);
   assign accept    = din_vld && din_rdy;
   assign last_edge = (state == RUN) && (cnt == LAST);
   assign init_val  = (din_first || !CHAIN_EN) ? IV : h_q;

   // NOTE: vn/wn are rewritten once per unrolled round, so they must use blocking
   // assignments here; every registered value below uses non-blocking ones.
   always_comb begin
      vn = v_q;
      wn = win_q;
      nw = '0;
      for (int r = 0; r < UNROLL; r++) begin
         vn = sha1_round(vn, wn[0], cnt + 7'(r));
         nw = wn[13] ^ wn[8] ^ wn[2] ^ wn[0];
         nw = {nw[30:0], nw[31]};
         for (int i = 0; i < 15; i++) wn[i] = wn[i + 1];
         wn[15] = nw;
      end
   end

   assign digest = {start_q[159:128] + vn[159:128], start_q[127:96] + vn[127:96],
                    start_q[95:64]   + vn[95:64],   start_q[63:32]  + vn[63:32],
                    start_q[31:0]    + vn[31:0]};

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (din_vld) state_nxt = RUN;
         RUN:     if (cnt == LAST) state_nxt = DONE;
         DONE:    if (dout_rdy) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         cnt   <= '0;
         h_q   <= IV;
         dout  <= '0;
      end else begin
         state <= state_nxt;
         if (accept) cnt <= '0;
         else if (state == RUN && cnt != LAST) cnt <= cnt + STEP;
         if (last_edge) begin
            dout <= digest;
            h_q  <= digest;
         end
      end
   end

   // NOTE: working state and schedule window are deliberately not reset; they are
   // always reloaded on accept before the FSM can consume them.
   always_ff @(posedge clk) begin
      if (accept) begin
         v_q     <= init_val;
         start_q <= init_val;
         for (int i = 0; i < 16; i++) win_q[i] <= din[511 - 32*i -: 32];
      end else if (state == RUN) begin
         v_q   <= vn;
         win_q <= wn;
      end
   end

endmodule

// File: tb/tb_sha1_iter.sv
// Directed bench for sha1_iter: four instances (UNROLL 1/5/20, and 20 without chaining)
// exercised one at a time against known FIPS 180 digests, latency and throughput.
module tb_sha1_iter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rstn;
   logic [511:0]  din;
   logic          din_first;
   logic [3:0]    vld, rdy, drdy, dvld, bsy;
   logic [159:0]  dout [4];
   int            tests = 0;
   int            fails = 0;

   localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
   localparam logic [511:0] BLK_M1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] BLK_M2    = {480'h0, 32'h000001c0};
   localparam logic [159:0] D_ABC     = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
   localparam logic [159:0] D_EMPTY   = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
   localparam logic [159:0] D_MULTI   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

   sha1_iter #(.UNROLL(1),  .CHAIN_EN(1'b1)) u_u1 (
      .clk(clk), .rstn(rstn), .din(din), .din_first(din_first), .din_vld(vld[0]),
      .din_rdy(drdy[0]), .dout(dout[0]), .dout_vld(dvld[0]), .dout_rdy(rdy[0]), .busy(bsy[0]));
   sha1_iter #(.UNROLL(5),  .CHAIN_EN(1'b1)) u_u5 (
      .clk(clk), .rstn(rstn), .din(din), .din_first(din_first), .din_vld(vld[1]),
      .din_rdy(drdy[1]), .dout(dout[1]), .dout_vld(dvld[1]), .dout_rdy(rdy[1]), .busy(bsy[1]));
   sha1_iter #(.UNROLL(20), .CHAIN_EN(1'b1)) u_u20 (
      .clk(clk), .rstn(rstn), .din(din), .din_first(din_first), .din_vld(vld[2]),
      .din_rdy(drdy[2]), .dout(dout[2]), .dout_vld(dvld[2]), .dout_rdy(rdy[2]), .busy(bsy[2]));
   sha1_iter #(.UNROLL(20), .CHAIN_EN(1'b0)) u_u20_nc (
      .clk(clk), .rstn(rstn), .din(din), .din_first(din_first), .din_vld(vld[3]),
      .din_rdy(drdy[3]), .dout(dout[3]), .dout_vld(dvld[3]), .dout_rdy(rdy[3]), .busy(bsy[3]));

   function automatic int exp_lat(input int k);
      case (k)
         0:       return 80;
         1:       return 16;
         default: return 4;
      endcase
   endfunction

   // Offers one block to instance k and returns edges from accept to dout_vld rising.
   task automatic send_block(input int k, input logic [511:0] blk, input logic first,
                             output int lat);
      int n = 0;
      while (!drdy[k] && n < 200) begin @(posedge clk); #1; n++; end
      din = blk; din_first = first; vld[k] = 1'b1;
      @(posedge clk); #1;
      vld[k] = 1'b0;
      lat = 0;
      while (!dvld[k] && lat < 200) begin @(posedge clk); #1; lat++; end
   endtask

   task automatic take_out(input int k);
      rdy[k] = 1'b1;
      @(posedge clk); #1;
      rdy[k] = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b1; vld = '0; rdy = '0; din = '0; din_first = 1'b0;
      #1 rstn = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (drdy[k] !== 1'b1 || bsy[k] !== 1'b0 || dvld[k] !== 1'b0 || dout[k] !== '0) begin
            fails++;
            $display("FAIL reset[%0d]: rdy=%b busy=%b vld=%b dout=%h, expected 1 0 0 0",
                     k, drdy[k], bsy[k], dvld[k], dout[k]);
         end
      end
      #20 rstn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_abc(input int k);
      int lat;
      send_block(k, BLK_ABC, 1'b1, lat);
      tests++;
      if (lat !== exp_lat(k)) begin
         fails++; $display("FAIL abc_latency[%0d]: got %0d expected %0d", k, lat, exp_lat(k));
      end
      tests++;
      if (dout[k] !== D_ABC) begin
         fails++; $display("FAIL abc_digest[%0d]: got %h expected %h", k, dout[k], D_ABC);
      end
      take_out(k);
   endtask

   task automatic test_empty(input int k);
      int lat;
      send_block(k, BLK_EMPTY, 1'b1, lat);
      tests++;
      if (dout[k] !== D_EMPTY || lat !== exp_lat(k)) begin
         fails++; $display("FAIL empty_digest[%0d]: got %h lat %0d expected %h lat %0d",
                           k, dout[k], lat, D_EMPTY, exp_lat(k));
      end
      take_out(k);
   endtask

   task automatic test_two_block(input int k);
      int lat;
      send_block(k, BLK_M1, 1'b1, lat);
      take_out(k);
      send_block(k, BLK_M2, 1'b0, lat);
      tests++;
      if (k < 3) begin
         if (dout[k] !== D_MULTI) begin
            fails++; $display("FAIL two_block[%0d]: got %h expected %h", k, dout[k], D_MULTI);
         end
      end else if (dout[k] === D_MULTI || dvld[k] !== 1'b1) begin
         fails++; $display("FAIL two_block_nochain[%0d]: got %h vld %b expected a digest other than %h",
                           k, dout[k], dvld[k], D_MULTI);
      end
      take_out(k);
   endtask

   task automatic test_hold(input int k);
      int lat;
      send_block(k, BLK_ABC, 1'b1, lat);
      for (int i = 0; i < 20; i++) begin
         din = BLK_EMPTY; din_first = 1'b1;
         vld[k] = (i % 4 == 1);
         @(posedge clk); #1;
         tests++;
         if (dvld[k] !== 1'b1 || drdy[k] !== 1'b0 || dout[k] !== D_ABC) begin
            fails++; $display("FAIL hold[%0d] cycle %0d: vld=%b rdy=%b dout=%h expected 1 0 %h",
                              k, i, dvld[k], drdy[k], dout[k], D_ABC);
         end
      end
      vld[k] = 1'b0;
      take_out(k);
      tests++;
      if (dvld[k] !== 1'b0 || drdy[k] !== 1'b1 || dout[k] !== D_ABC) begin
         fails++; $display("FAIL hold_release[%0d]: vld=%b rdy=%b dout=%h expected 0 1 %h",
                           k, dvld[k], drdy[k], dout[k], D_ABC);
      end
      take_out(k);
      tests++;
      if (dvld[k] !== 1'b0 || drdy[k] !== 1'b1 || bsy[k] !== 1'b0) begin
         fails++; $display("FAIL idle_dout_rdy[%0d]: vld=%b rdy=%b busy=%b expected 0 1 0",
                           k, dvld[k], drdy[k], bsy[k]);
      end
   endtask

   task automatic test_back_to_back(input int k);
      int rise_at [2];
      int rises = 0;
      int n = 0;
      logic prev = 1'b0;
      rise_at[0] = 0; rise_at[1] = 0;
      din = BLK_ABC; din_first = 1'b1; rdy[k] = 1'b1; vld[k] = 1'b1;
      for (int cyc = 0; cyc < 400 && rises < 2; cyc++) begin
         @(posedge clk); #1;
         if (dvld[k] && !prev) begin
            rise_at[rises] = cyc;
            rises++;
            tests++;
            if (dout[k] !== D_ABC) begin
               fails++; $display("FAIL b2b_digest[%0d]: got %h expected %h", k, dout[k], D_ABC);
            end
         end
         prev = dvld[k];
      end
      vld[k] = 1'b0;
      tests++;
      if (rises != 2 || rise_at[1] - rise_at[0] != exp_lat(k) + 2) begin
         fails++; $display("FAIL b2b_throughput[%0d]: %0d digests, period %0d expected 2 period %0d",
                           k, rises, rise_at[1] - rise_at[0], exp_lat(k) + 2);
      end
      while ((!drdy[k] || bsy[k]) && n < 300) begin @(posedge clk); #1; n++; end
      rdy[k] = 1'b0;
   endtask

   task automatic test_reset_mid(input int k);
      int lat;
      int n = 0;
      while (!drdy[k] && n < 200) begin @(posedge clk); #1; n++; end
      din = BLK_ABC; din_first = 1'b1; vld[k] = 1'b1;
      @(posedge clk); #1;
      vld[k] = 1'b0;
      repeat (exp_lat(k) / 2) @(posedge clk);
      #1;
      tests++;
      if (bsy[k] !== 1'b1) begin
         fails++; $display("FAIL mid_busy[%0d]: got %b expected 1", k, bsy[k]);
      end
      rstn = 1'b0;
      #1;
      tests++;
      if (drdy[k] !== 1'b1 || bsy[k] !== 1'b0 || dvld[k] !== 1'b0 || dout[k] !== '0) begin
         fails++; $display("FAIL mid_reset[%0d]: rdy=%b busy=%b vld=%b dout=%h expected 1 0 0 0",
                           k, drdy[k], bsy[k], dvld[k], dout[k]);
      end
      #2 rstn = 1'b1;
      send_block(k, BLK_ABC, 1'b0, lat);
      tests++;
      if (dout[k] !== D_ABC || lat !== exp_lat(k)) begin
         fails++; $display("FAIL post_reset_abc[%0d]: got %h lat %0d expected %h lat %0d",
                           k, dout[k], lat, D_ABC, exp_lat(k));
      end
      take_out(k);
   endtask

   initial begin
      test_reset();
      for (int k = 0; k < 4; k++) begin
         test_abc(k);
         test_empty(k);
         test_two_block(k);
         test_hold(k);
         test_back_to_back(k);
         test_reset_mid(k);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
